// File: rtl/rib_ex_bridge_pkg.sv
// Shared types and defaults for the core-to-handshake data-memory bridge.
package rib_ex_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          TMR_W         = 16;
  localparam int          TIMEOUT_DEF   = 255;
  localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

endpackage

// File: rtl/rib_ex_bridge.sv
// Bridges the core's single-cycle ex-stage memory port onto a req/gnt/rvalid
// slave handshake, stalling the core until done; aborts hung slaves on timeout.
module rib_ex_bridge
  import rib_ex_bridge_pkg::*;
#(
  parameter int          TIMEOUT   = TIMEOUT_DEF,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_data_i,
  input  logic        ex_req_i,
  input  logic        ex_we_i,
  output logic [31:0] ex_data_o,
  output logic        hold_flag_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               timer_last;
  logic               abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign timer_last = (timer_q == TMR_LAST);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    timer_d    = timer_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_req_i) begin
          addr_d  = ex_addr_i;
          wdata_d = ex_data_i;
          we_d    = ex_we_i;
          timer_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_d = timer_q + 1'b1;
        // A read grant on the last allowed cycle cannot finish in time, so it aborts.
        if (m_gnt_i && we_q)  state_d = ST_DONE;
        else if (timer_last)  abort   = 1'b1;
        else if (m_gnt_i)     state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (m_rvalid_i) begin
          rdata_d = m_rdata_i;
          state_d = ST_DONE;
        end else if (timer_last) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      rdata_d = ERR_RDATA;
      state_d = ST_DONE;
      err_d   = 1'b1;
      if (!err_q) err_addr_d = addr_q;
    end
  end

  assign hold_flag_o = ((state_q == ST_IDLE) && ex_req_i) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign m_req_o     = (state_q == ST_REQ);
  assign m_we_o      = m_req_o && we_q;
  assign m_addr_o    = m_req_o ? addr_q  : '0;
  assign m_wdata_o   = m_req_o ? wdata_q : '0;
  assign ex_data_o   = ((state_q == ST_DONE) && !we_q) ? rdata_q : '0;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_rib_ex_bridge.sv
// Randomized bench for rib_ex_bridge: each transfer's expected timing and data
// come from a per-transaction model of slave grant/response delays.
module tb_rib_ex_bridge;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_addr_i = '0, ex_data_i = '0;
  logic        ex_req_i = 1'b0, ex_we_i = 1'b0;
  logic [31:0] ex_data_o;
  logic        hold_flag_o, m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic        m_gnt_i = 1'b0, m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;
  logic        err_o;
  logic [31:0] err_addr_o;

  int total = 0;
  int bad   = 0;

  logic        err_exp      = 1'b0;
  logic [31:0] err_addr_exp = '0;

  rib_ex_bridge #(.TIMEOUT(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i), .ex_req_i(ex_req_i), .ex_we_i(ex_we_i),
    .ex_data_o(ex_data_o), .hold_flag_o(hold_flag_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .err_o(err_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One core access; slave grants after g REQ cycles and answers r cycles
  // after the grant (r<0: never). Core holds the request through DONE.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int g, input int r, input bit spur);
    int cg, cr, done, req_end;
    bit to;
    logic [31:0] exp_data;
    cg = 1 + g;
    cr = (r < 0) ? 1000 : cg + 1 + r;
    if (we) to = (cg > T);
    else    to = (cg >= T) || (cr > T);
    done     = to ? T + 1 : (we ? cg + 1 : cr + 1);
    req_end  = (cg < T) ? cg : T;
    exp_data = we ? 32'h0 : (to ? ERR : rd);
    for (int k = 0; k <= done; k++) begin
      ex_req_i   = 1'b1;
      ex_we_i    = we;
      ex_addr_i  = addr;
      ex_data_i  = wd;
      m_gnt_i    = (k == cg);
      m_rvalid_i = (k == cr) || (spur && k == 1 && cg > 1);
      m_rdata_i  = (k == cr) ? rd : $urandom;
      @(negedge clk);
      chk("hold", {31'b0, hold_flag_o}, {31'b0, k < done});
      chk("m_req", {31'b0, m_req_o}, {31'b0, (k >= 1) && (k <= req_end)});
      if ((k >= 1) && (k <= req_end)) begin
        chk("m_addr", m_addr_o, addr);
        chk("m_we", {31'b0, m_we_o}, {31'b0, we});
        if (we) chk("m_wdata", m_wdata_o, wd);
      end else begin
        chk("m_addr_idle", m_addr_o, 32'h0);
      end
      if (k == done && to) begin
        if (!err_exp) err_addr_exp = addr;
        err_exp = 1'b1;
      end
      chk("ex_data", ex_data_o, (k == done) ? exp_data : 32'h0);
      if (k == done) begin
        chk("err", {31'b0, err_o}, {31'b0, err_exp});
        chk("err_addr", err_addr_o, err_addr_exp);
      end
      @(posedge clk); #1;
    end
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
  endtask

  // Idle core with stray slave responses that must be ignored.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      ex_req_i   = 1'b0;
      ex_addr_i  = $urandom;
      m_gnt_i    = $urandom_range(0, 1) == 1;
      m_rvalid_i = $urandom_range(0, 1) == 1;
      m_rdata_i  = $urandom;
      @(negedge clk);
      chk("idle_hold", {31'b0, hold_flag_o}, 32'h0);
      chk("idle_m_req", {31'b0, m_req_o}, 32'h0);
      chk("idle_ex_data", ex_data_o, 32'h0);
      chk("idle_err", {31'b0, err_o}, {31'b0, err_exp});
      @(posedge clk); #1;
    end
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_m_req", {31'b0, m_req_o}, 32'h0);
    chk("rst_hold", {31'b0, hold_flag_o}, 32'h0);
    chk("rst_ex_data", ex_data_o, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_err_addr", err_addr_o, 32'h0);
    chk("rst_m_addr", m_addr_o, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    idle_cycles(1);
    run_txn(1'b1, 32'h1000_0004, 32'h55, 32'h0, 4, 0, 1'b0);
    run_txn(1'b0, 32'h2000_0008, 32'h0, 32'h1234_5678, 2, 1, 1'b1);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 32'h0, 0, -1, 1'b0);
    idle_cycles(2);
    run_txn(1'b0, 32'h4000_0010, 32'h0, 32'h0, 0, -1, 1'b0);
    run_txn(1'b1, 32'h5000_0000, 32'h77, 32'h0, 7, 0, 1'b0);
    run_txn(1'b0, 32'h6000_0000, 32'h0, 32'hAAAA_5555, 6, 0, 1'b0);
    run_txn(1'b0, 32'h7000_0000, 32'h0, 32'h1111_2222, 7, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0000, 32'h0, 32'h3333_4444, 0, 1, 1'b1);
    run_txn(1'b1, 32'h9000_0000, 32'h99, 32'h0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int g, r;
      g = $urandom_range(0, 9);
      r = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 7);
      run_txn($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, g, r,
              $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    // reset asserted while waiting for read data
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'hABCD_0000;
    @(posedge clk); #1;
    m_gnt_i = 1'b1;
    @(posedge clk); #1;
    m_gnt_i = 1'b0;
    #2;
    rst = 1'b0; ex_req_i = 1'b0;
    #1;
    chk("mid_rst_m_req", {31'b0, m_req_o}, 32'h0);
    chk("mid_rst_hold", {31'b0, hold_flag_o}, 32'h0);
    chk("mid_rst_err", {31'b0, err_o}, 32'h0);
    chk("mid_rst_err_addr", err_addr_o, 32'h0);
    err_exp = 1'b0; err_addr_exp = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_CAFE, 1, 2, 1'b0);
    run_txn(1'b1, 32'h0000_0204, 32'hFEED, 32'h0, 0, 0, 1'b0);
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
